// File: rtl/wb_timer_multi_if.sv
// Wishbone slave bus bundle for wb_timer_multi; names follow the classic _i/_o
// direction as seen from the timer.
interface wb_timer_multi_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_timer_multi.sv
// NCHAN compare/match timers sharing one prescaler, on a Wishbone slave with a
// registered single-cycle ack (2 cycles per transfer); intr = STATUS & IE.
module wb_timer_multi #(
  parameter int NCHAN = 4,
  parameter int WIDTH = 32,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  wb_timer_multi_if.slave  wb,
  output logic [NCHAN-1:0] intr
);
  localparam logic [3:0] NCH4 = 4'(NCHAN);

  logic [NCHAN-1:0] r_en, r_ar, r_ie, r_status;
  logic [WIDTH-1:0] r_cmp [NCHAN];
  logic [WIDTH-1:0] r_cnt [NCHAN];
  logic [PRE_W-1:0] r_prescale, r_pre_cnt;
  logic             r_ack;
  logic [31:0]      r_dat;

  logic             w_req, w_wr, w_glb, w_ch_ok, w_stat_sel, w_pre_sel, w_tick;
  logic [2:0]       w_ch;
  logic [1:0]       w_reg;
  logic [NCHAN-1:0] w_wr_ctrl, w_wr_cmp, w_wr_cnt, w_match, w_clr;
  logic [31:0]      w_rdata;
  logic             w_unused_adr;

  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] sel);
    logic [31:0] v;
    for (int b = 0; b < 4; b++) v[8*b +: 8] = sel[b] ? dat[8*b +: 8] : old[8*b +: 8];
    return v;
  endfunction

  assign w_req        = wb.wb_stb_i & wb.wb_cyc_i & ~r_ack;
  assign w_wr         = w_req & wb.wb_we_i;
  assign w_glb        = wb.wb_adr_i[7];
  assign w_ch         = wb.wb_adr_i[6:4];
  assign w_reg        = wb.wb_adr_i[3:2];
  assign w_ch_ok      = !w_glb && ({1'b0, w_ch} < NCH4);
  assign w_stat_sel   = w_glb && (wb.wb_adr_i[6:2] == 5'd0);
  assign w_pre_sel    = w_glb && (wb.wb_adr_i[6:2] == 5'd1);
  assign w_tick       = (r_pre_cnt == r_prescale);
  assign w_unused_adr = ^{wb.wb_adr_i[31:8], wb.wb_adr_i[1:0]};

  // A COUNTER write on a tick suppresses the match evaluation for that channel.
  always_comb begin
    w_wr_ctrl = '0;
    w_wr_cmp  = '0;
    w_wr_cnt  = '0;
    w_match   = '0;
    w_clr     = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (w_wr && w_ch_ok && (w_ch == 3'(c))) begin
        w_wr_ctrl[c] = (w_reg == 2'd0) && wb.wb_sel_i[0];
        w_wr_cmp[c]  = (w_reg == 2'd1);
        w_wr_cnt[c]  = (w_reg == 2'd2);
      end
      w_clr[c]   = w_wr && w_stat_sel && wb.wb_sel_i[0] && wb.wb_dat_i[c];
      w_match[c] = w_tick && r_en[c] && !w_wr_cnt[c] && (r_cnt[c] == r_cmp[c]);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_pre_sel) begin
      w_rdata = 32'(r_prescale);
    end else if (w_stat_sel) begin
      w_rdata = 32'(r_status);
    end else if (w_ch_ok) begin
      for (int c = 0; c < NCHAN; c++) begin
        if (w_ch == 3'(c)) begin
          case (w_reg)
            2'd0:    w_rdata = {29'd0, r_ie[c], r_ar[c], r_en[c]};
            2'd1:    w_rdata = 32'(r_cmp[c]);
            2'd2:    w_rdata = 32'(r_cnt[c]);
            default: w_rdata = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_req ? w_rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prescale <= '0;
      r_pre_cnt  <= '0;
    end else if (w_wr && w_pre_sel) begin
      r_prescale <= PRE_W'(f_merge(32'(r_prescale), wb.wb_dat_i, wb.wb_sel_i));
      r_pre_cnt  <= '0;
    end else if (w_tick) begin
      r_pre_cnt  <= '0;
    end else begin
      r_pre_cnt  <= r_pre_cnt + PRE_W'(1);
    end
  end

  // A CTRL write beats the one-shot EN clear; a new match beats a W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en     <= '0;
      r_ar     <= '0;
      r_ie     <= '0;
      r_status <= '0;
      for (int c = 0; c < NCHAN; c++) begin
        r_cmp[c] <= '0;
        r_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        if (w_wr_ctrl[c]) begin
          r_en[c] <= wb.wb_dat_i[0];
          r_ar[c] <= wb.wb_dat_i[1];
          r_ie[c] <= wb.wb_dat_i[2];
        end else if (w_match[c] && !r_ar[c]) begin
          r_en[c] <= 1'b0;
        end
        if (w_wr_cmp[c])
          r_cmp[c] <= WIDTH'(f_merge(32'(r_cmp[c]), wb.wb_dat_i, wb.wb_sel_i));
        if (w_wr_cnt[c])
          r_cnt[c] <= WIDTH'(f_merge(32'(r_cnt[c]), wb.wb_dat_i, wb.wb_sel_i));
        else if (w_tick && r_en[c])
          r_cnt[c] <= w_match[c] ? '0 : r_cnt[c] + WIDTH'(1);
        r_status[c] <= w_match[c] | (r_status[c] & ~w_clr[c]);
      end
    end
  end

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_dat_o = r_dat;
  assign intr        = r_status & r_ie;
endmodule

// File: tb/tb_wb_timer_multi.sv
// Directed bench: default instance for timing/feature vectors, NCHAN=2/WIDTH=16
// instance for decode and width limits.
module tb_wb_timer_multi;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] intr_a;
  logic [1:0] intr_b;
  int         n_chk = 0;
  int         n_pass = 0;

  wb_timer_multi_if bus_a ();
  wb_timer_multi_if bus_b ();

  wb_timer_multi u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (bus_a),
    .intr    (intr_a)
  );

  wb_timer_multi #(.NCHAN(2), .WIDTH(16), .PRE_W(16)) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (bus_b),
    .intr    (intr_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic bus_idle();
    bus_a.wb_stb_i = 1'b0; bus_a.wb_cyc_i = 1'b0; bus_a.wb_we_i = 1'b0;
    bus_a.wb_sel_i = 4'h0; bus_a.wb_adr_i = '0;   bus_a.wb_dat_i = '0;
    bus_b.wb_stb_i = 1'b0; bus_b.wb_cyc_i = 1'b0; bus_b.wb_we_i = 1'b0;
    bus_b.wb_sel_i = 4'h0; bus_b.wb_adr_i = '0;   bus_b.wb_dat_i = '0;
  endtask

  // Starts just after a rising edge; commit edge is the next one, ends 1 after the following edge.
  task automatic xfer(input bit d2, input bit we, input logic [7:0] adr, input logic [31:0] wdat,
                      input logic [3:0] sel, output logic [31:0] rdat, output logic [31:0] irq);
    if (d2) begin
      bus_b.wb_adr_i = {24'd0, adr}; bus_b.wb_dat_i = wdat; bus_b.wb_sel_i = sel;
      bus_b.wb_we_i = we; bus_b.wb_stb_i = 1'b1; bus_b.wb_cyc_i = 1'b1;
    end else begin
      bus_a.wb_adr_i = {24'd0, adr}; bus_a.wb_dat_i = wdat; bus_a.wb_sel_i = sel;
      bus_a.wb_we_i = we; bus_a.wb_stb_i = 1'b1; bus_a.wb_cyc_i = 1'b1;
    end
    @(posedge clk); #1;
    chk("ack_rise", d2 ? 32'(bus_b.wb_ack_o) : 32'(bus_a.wb_ack_o), 32'd1);
    rdat = d2 ? bus_b.wb_dat_o : bus_a.wb_dat_o;
    irq  = 32'(intr_a);
    bus_idle();
    @(posedge clk); #1;
    chk("ack_fall", d2 ? 32'(bus_b.wb_ack_o) : 32'(bus_a.wb_ack_o), 32'd0);
  endtask

  task automatic wr(input logic [7:0] adr, input logic [31:0] d);
    logic [31:0] r, q;
    xfer(1'b0, 1'b1, adr, d, 4'hF, r, q);
  endtask

  task automatic wrs(input logic [7:0] adr, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] r, q;
    xfer(1'b0, 1'b1, adr, d, sel, r, q);
  endtask

  task automatic wrb(input logic [7:0] adr, input logic [31:0] d);
    logic [31:0] r, q;
    xfer(1'b1, 1'b1, adr, d, 4'hF, r, q);
  endtask

  task automatic wr_irq(input logic [7:0] adr, input logic [31:0] d, output logic [31:0] irq);
    logic [31:0] r;
    xfer(1'b0, 1'b1, adr, d, 4'hF, r, irq);
  endtask

  task automatic rd(input string tag, input bit d2, input logic [7:0] adr, input logic [31:0] exp);
    logic [31:0] r, q;
    xfer(d2, 1'b0, adr, 32'd0, 4'hF, r, q);
    chk(tag, r, exp);
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    bus_idle();
    reset_n = 1'b0;
    #12;
    chk("rst_ack",    32'(bus_a.wb_ack_o), 32'd0);
    chk("rst_dat",    bus_a.wb_dat_o,      32'd0);
    chk("rst_intr_a", 32'(intr_a),         32'd0);
    chk("rst_intr_b", 32'(intr_b),         32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    rd("rst_ctrl0", 1'b0, 8'h00, 32'd0);
    rd("rst_cnt0",  1'b0, 8'h08, 32'd0);
    rd("rst_pre",   1'b0, 8'h84, 32'd0);
    rd("rst_stat",  1'b0, 8'h80, 32'd0);

    // ch0 auto-reload, COMPARE=4, PRESCALE=0: period 5 clocks
    wr(8'h04, 32'd4);
    wr(8'h00, 32'h7);
    tick_n(3); chk("ar_before", 32'(intr_a), 32'h0);
    tick_n(1); chk("ar_first",  32'(intr_a), 32'h1);
    wr(8'h80, 32'h1);
    chk("ar_cleared", 32'(intr_a), 32'h0);
    tick_n(2); chk("ar_gap",    32'(intr_a), 32'h0);
    tick_n(1); chk("ar_second", 32'(intr_a), 32'h1);
    wr(8'h00, 32'h0);
    wr(8'h80, 32'hF);

    // ch1 one-shot, PRESCALE=3, COMPARE=2: match 12 clocks after prescaler restart
    wr(8'h14, 32'd2);
    wr(8'h84, 32'd3);
    wr(8'h10, 32'h5);
    tick_n(8); chk("os_before", 32'(intr_a), 32'h0);
    tick_n(1); chk("os_match",  32'(intr_a), 32'h2);
    rd("os_ctrl", 1'b0, 8'h10, 32'h4);
    rd("os_cnt",  1'b0, 8'h18, 32'h0);
    chk("os_hold", 32'(intr_a), 32'h2);
    rd("os_stat", 1'b0, 8'h80, 32'h2);
    wr(8'h80, 32'h2);
    chk("os_clr", 32'(intr_a), 32'h0);

    // ch3: COUNTER write on a tick wins over the count, match on the next tick
    wr(8'h34, 32'h10);
    wr(8'h84, 32'd3);
    wr(8'h30, 32'h7);
    tick_n(4);
    wr(8'h38, 32'h10);
    chk("cw_nomatch", 32'(intr_a), 32'h0);
    rd("cw_cnt", 1'b0, 8'h38, 32'h10);
    chk("cw_still", 32'(intr_a), 32'h0);
    tick_n(1); chk("cw_match", 32'(intr_a), 32'h8);
    wr(8'h30, 32'h0);
    wr(8'h80, 32'h8);

    // ch2 COMPARE=0, PRESCALE=0: W1C on a match cycle leaves the bit set
    wr(8'h84, 32'd0);
    wr(8'h24, 32'd0);
    wr(8'h20, 32'h7);
    wr_irq(8'h80, 32'h4, q);
    chk("w1c_match", q, 32'h4);
    rd("w1c_stat", 1'b0, 8'h80, 32'h4);
    wr(8'h20, 32'h0);
    wr_irq(8'h80, 32'h4, q);
    chk("w1c_idle", q, 32'h0);

    // ch2 one-shot COMPARE=1: CTRL write on the match edge keeps EN
    wr(8'h24, 32'd1);
    wr(8'h20, 32'h1);
    wr(8'h20, 32'h1);
    rd("ctl_cnt",  1'b0, 8'h28, 32'h1);
    rd("ctl_ctrl", 1'b0, 8'h20, 32'h0);
    rd("ctl_cnt2", 1'b0, 8'h28, 32'h0);
    wr(8'h80, 32'h4);

    // Byte lanes, reserved and unmapped decode
    wrs(8'h04, 32'hAABBCCDD, 4'b0101);
    rd("lane_cmp", 1'b0, 8'h04, 32'h00BB00DD);
    wrs(8'h00, 32'h7, 4'b1110);
    rd("lane_ctrl", 1'b0, 8'h00, 32'h0);
    wr(8'h0C, 32'hFFFFFFFF);
    rd("resv", 1'b0, 8'h0C, 32'h0);
    wr(8'h84, 32'h00012345);
    rd("pre_w", 1'b0, 8'h84, 32'h2345);
    wr(8'h84, 32'h0);
    rd("unmap", 1'b0, 8'h88, 32'h0);

    // NCHAN=2, WIDTH=16 instance
    wrb(8'h20, 32'h7);
    rd("b_ch2", 1'b1, 8'h20, 32'h0);
    wrb(8'h04, 32'hFFFFFFFF);
    rd("b_cmp16", 1'b1, 8'h04, 32'h0000FFFF);
    rd("b_cnt", 1'b1, 8'h08, 32'h0);

    // Reset while ch0 runs and a ch1 COMPARE write is pending
    wr(8'h04, 32'd3);
    wr(8'h00, 32'h7);
    bus_a.wb_adr_i = 32'h14; bus_a.wb_dat_i = 32'h55; bus_a.wb_sel_i = 4'hF;
    bus_a.wb_we_i = 1'b1; bus_a.wb_stb_i = 1'b1; bus_a.wb_cyc_i = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_ack",  32'(bus_a.wb_ack_o), 32'd0);
    chk("mid_intr", 32'(intr_a),         32'd0);
    chk("mid_dat",  bus_a.wb_dat_o,      32'd0);
    @(posedge clk); #1;
    chk("mid_ack_hold", 32'(bus_a.wb_ack_o), 32'd0);
    bus_idle();
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_ack",  32'(bus_a.wb_ack_o), 32'd0);
    chk("post_intr", 32'(intr_a),         32'd0);
    rd("post_cmp1",  1'b0, 8'h14, 32'h0);
    rd("post_ctrl0", 1'b0, 8'h00, 32'h0);
    rd("post_cmp0",  1'b0, 8'h04, 32'h0);
    rd("post_cnt0",  1'b0, 8'h08, 32'h0);
    rd("post_pre",   1'b0, 8'h84, 32'h0);
    rd("post_stat",  1'b0, 8'h80, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
